// File: rtl/fetch_bpu_pkg.sv
// Shared constants and helpers for the fetch stage and its branch predictor.
package fetch_bpu_pkg;

  // MIPS opcode / funct encodings used by the pre-decoder.
  localparam logic [5:0] OPCODE_I_BEQ    = 6'b000100;
  localparam logic [5:0] OPCODE_I_BNE    = 6'b000101;
  localparam logic [5:0] OPCODE_J_JUMP   = 6'b000010;
  localparam logic [5:0] OPCODE_JAL_JUMP = 6'b000011;
  localparam logic [5:0] OPCODE_R        = 6'b000000;
  localparam logic [5:0] R_FUNC_JR       = 6'b001000;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // A freshly allocated BTB entry starts weakly taken.
  localparam logic [1:0] BTB_CTR_INIT = 2'b10;

  // Control-flow class of the instruction currently being fetched.
  typedef struct packed {
    logic br;    // BEQ / BNE
    logic j;     // J
    logic jal;   // JAL
    logic jr31;  // JR $31 (function return)
  } predec_t;

  function automatic predec_t predecode(input logic [31:0] instr);
    predec_t d;
    d.br   = (instr[31:26] == OPCODE_I_BEQ) || (instr[31:26] == OPCODE_I_BNE);
    d.j    = (instr[31:26] == OPCODE_J_JUMP);
    d.jal  = (instr[31:26] == OPCODE_JAL_JUMP);
    d.jr31 = (instr[31:26] == OPCODE_R) && (instr[5:0] == R_FUNC_JR) &&
             (instr[25:21] == 5'd31);
    return d;
  endfunction

  // 2-bit saturating counter step.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/fetch_bpu_ras_stack.sv
// Return-address stack: circular buffer that overwrites the oldest entry when
// full and ignores pops when empty.
module ras_stack #(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [31:0]              data_i,
  output logic [31:0]              top_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [31:0]     mem_q [Depth];
  logic [PtrW-1:0] ptr_q, ptr_d;   // next slot to write
  logic [PtrW:0]   cnt_q, cnt_d;
  logic [PtrW-1:0] top_ptr;

  assign top_ptr = ptr_q - PtrW'(1);
  assign top_o   = mem_q[top_ptr];
  assign count_o = cnt_q;

  // Pointer/count next state; the pointer wraps naturally at a power-of-two depth.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + 1'b1;
      if (cnt_q != (PtrW + 1)'(Depth)) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_bpu.sv
// Instruction-fetch stage with a tagged 2-bit BTB, direct J/JAL targets and a
// return-address stack for JR $31.
module fetch_bpu
  import fetch_bpu_pkg::*;
#(
  parameter int unsigned BTB_AW    = 6,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned RAS_DEPTH = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        isHazard,
  input  logic        isCacheStall,
  input  logic        isFlush,
  input  logic [31:0] flush_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [31:0] reg_pc,
  output logic [31:0] reg_id_pc,
  output logic [31:0] reg_instruction,
  output logic        reg_pred_taken,
  output logic [31:0] reg_pred_target
);

  localparam int unsigned BtbEntries = 1 << BTB_AW;
  localparam int unsigned CntW       = $clog2(RAS_DEPTH) + 1;
  localparam int unsigned TagLo      = BTB_AW + 2;
  localparam int unsigned TagHi      = BTB_AW + 2 + TAG_W - 1;

  // Pipeline registers.
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        ptk_q, ptk_d;
  logic [31:0] ptgt_q, ptgt_d;

  // BTB storage; only the valid vector is reset.
  logic [BtbEntries-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q [BtbEntries];
  logic [31:0]           tgt_q [BtbEntries];
  logic [1:0]            ctr_q [BtbEntries];

  logic [BTB_AW-1:0] idx, uidx;
  logic [TAG_W-1:0]  tag, utag;
  logic              hit, uhit;

  predec_t     dec;
  logic [31:0] pc4, jmp_tgt, npc;
  logic        taken, use_ras, advance;

  logic [31:0]     ras_top;
  logic [CntW-1:0] ras_count;
  logic            ras_push, ras_pop;

  logic unused_upd_pc;
  assign unused_upd_pc = ^{upd_pc[1:0], upd_pc[31:TagHi+1]};

  assign idx  = pc_q[BTB_AW+1:2];
  assign tag  = pc_q[TagHi:TagLo];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign uidx = upd_pc[BTB_AW+1:2];
  assign utag = upd_pc[TagHi:TagLo];
  assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

  assign dec     = predecode(instruction);
  assign pc4     = pc_q + 32'd4;
  assign jmp_tgt = {pc4[31:28], instruction[25:0], 2'b00};
  assign advance = !isFlush && !isHazard && !isCacheStall;

  // Next-PC prediction from the pre-decoded fetch word (reads pre-update BTB).
  always_comb begin
    npc     = pc4;
    taken   = 1'b0;
    use_ras = 1'b0;
    if (dec.br && hit && ctr_q[idx][1]) begin
      npc   = tgt_q[idx];
      taken = 1'b1;
    end else if (dec.j || dec.jal) begin
      npc   = jmp_tgt;
      taken = 1'b1;
    end else if (dec.jr31 && (ras_count != '0)) begin
      npc     = ras_top;
      taken   = 1'b1;
      use_ras = 1'b1;
    end
  end

  // No delay slot, so a call returns to the word right after the JAL.
  assign ras_push = advance && dec.jal;
  assign ras_pop  = advance && use_ras;

  ras_stack #(
    .Depth (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc4),
    .top_o   (ras_top),
    .count_o (ras_count)
  );

  // Pipeline next state: flush beats stall beats advance.
  always_comb begin
    pc_d    = pc_q;
    id_pc_d = id_pc_q;
    instr_d = instr_q;
    ptk_d   = ptk_q;
    ptgt_d  = ptgt_q;
    if (isFlush) begin
      pc_d    = flush_pc;
      id_pc_d = 32'h0;
      instr_d = NOP;
      ptk_d   = 1'b0;
    end else if (advance) begin
      pc_d    = npc;
      id_pc_d = pc_q;
      instr_d = instruction;
      ptk_d   = taken;
      ptgt_d  = npc;
    end
  end

  // A taken miss allocates a new entry.
  always_comb begin
    valid_d = valid_q;
    if (upd_valid && upd_taken && !uhit) valid_d[uidx] = 1'b1;
  end

  // Pipeline and BTB-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      id_pc_q <= 32'h0;
      instr_q <= NOP;
      ptk_q   <= 1'b0;
      ptgt_q  <= 32'h0;
      valid_q <= '0;
    end else begin
      pc_q    <= pc_d;
      id_pc_q <= id_pc_d;
      instr_q <= instr_d;
      ptk_q   <= ptk_d;
      ptgt_q  <= ptgt_d;
      valid_q <= valid_d;
    end
  end

  // BTB training from the EX resolve port, independent of stall and flush.
  always_ff @(posedge clk) begin
    if (upd_valid) begin
      if (uhit) begin
        ctr_q[uidx] <= ctr_next(ctr_q[uidx], upd_taken);
        if (upd_taken) tgt_q[uidx] <= upd_target;
      end else if (upd_taken) begin
        tag_q[uidx] <= utag;
        tgt_q[uidx] <= upd_target;
        ctr_q[uidx] <= BTB_CTR_INIT;
      end
    end
  end

  assign reg_pc          = pc_q;
  assign reg_id_pc       = id_pc_q;
  assign reg_instruction = instr_q;
  assign reg_pred_taken  = ptk_q;
  assign reg_pred_target = ptgt_q;

endmodule

// File: tb/tb_fetch_bpu.sv
// Self-checking bench for fetch_bpu: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the fetch rules.
module tb_fetch_bpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        isHazard, isCacheStall, isFlush;
  logic [31:0] flush_pc;
  logic        upd_valid, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic [31:0] reg_pc, reg_id_pc, reg_instruction, reg_pred_target;
  logic        reg_pred_taken;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [31:0] W_JR31 = 32'h03E0_0008;
  localparam logic [31:0] W_BEQ  = 32'h1000_0004;

  always #5 clk = ~clk;

  fetch_bpu #(
    .BTB_AW    (6),
    .TAG_W     (8),
    .RAS_DEPTH (4),
    .RESET_PC  (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instruction     (instruction),
    .isHazard        (isHazard),
    .isCacheStall    (isCacheStall),
    .isFlush         (isFlush),
    .flush_pc        (flush_pc),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_target      (upd_target),
    .upd_taken       (upd_taken),
    .reg_pc          (reg_pc),
    .reg_id_pc       (reg_id_pc),
    .reg_instruction (reg_instruction),
    .reg_pred_taken  (reg_pred_taken),
    .reg_pred_target (reg_pred_target)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] imem [logic [31:0]];
  logic [31:0] m_pc, m_id_pc, m_instr, m_ptgt;
  logic        m_ptk;
  bit          m_valid [64];
  logic [31:0] m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_ctr [64];
  logic [31:0] ras [$];

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] jal_word(input logic [31:0] t);
    return {6'h03, t[27:2]};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_id_pc = 0; m_instr = 0; m_ptk = 0; m_ptgt = 0;
    foreach (m_valid[i]) m_valid[i] = 0;
    ras.delete();
  endtask

  // Drive one cycle of inputs, advance the model, then wait past the edge.
  task automatic step(input bit hz, input bit cs, input bit fl, input logic [31:0] fpc,
                      input bit uv, input logic [31:0] upc, input logic [31:0] utg,
                      input bit utk);
    logic [31:0] ins, pc4, npc;
    logic [5:0]  op;
    bit          tk, ret;
    int          i, ui;
    ins = fetch_word(m_pc);
    instruction = ins; isHazard = hz; isCacheStall = cs; isFlush = fl; flush_pc = fpc;
    upd_valid = uv; upd_pc = upc; upd_target = utg; upd_taken = utk;
    op  = ins[31:26];
    pc4 = m_pc + 4;
    npc = pc4; tk = 0; ret = 0;
    i = int'((m_pc >> 2) % 64);
    if ((op == 6'h04 || op == 6'h05) && m_valid[i] && m_tag[i] == ((m_pc >> 8) & 255) &&
        m_ctr[i] >= 2) begin
      npc = m_tgt[i]; tk = 1;
    end else if (op == 6'h02 || op == 6'h03) begin
      npc = (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2); tk = 1;
    end else if (op == 6'h00 && ins[5:0] == 6'h08 && ins[25:21] == 5'd31 && ras.size() > 0)
    begin
      npc = ras[$]; tk = 1; ret = 1;
    end
    if (fl) begin
      m_pc = fpc; m_instr = 0; m_ptk = 0; m_id_pc = 0;
    end else if (!(hz || cs)) begin
      if (op == 6'h03) begin
        ras.push_back(pc4);
        if (ras.size() > 4) void'(ras.pop_front());
      end
      if (ret) void'(ras.pop_back());
      m_id_pc = m_pc; m_instr = ins; m_ptk = tk; m_ptgt = npc; m_pc = npc;
    end
    if (uv) begin
      ui = int'((upc >> 2) % 64);
      if (m_valid[ui] && m_tag[ui] == ((upc >> 8) & 255)) begin
        if (utk) begin
          m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
          m_tgt[ui] = utg;
        end else begin
          m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        end
      end else if (utk) begin
        m_valid[ui] = 1; m_tag[ui] = (upc >> 8) & 255; m_tgt[ui] = utg; m_ctr[ui] = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic adv();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic flush_to(input logic [31:0] a);
    step(0, 0, 1, a, 0, 0, 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    instruction = 0; isHazard = 0; isCacheStall = 0; isFlush = 0; flush_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
    model_reset();
    #1;
    n_cmp++; if (reg_pc !== 32'h0) begin n_fail++;
      $display("FAIL reset_pc: got %h want %h", reg_pc, 32'h0); end
    n_cmp++; if (reg_instruction !== 32'h0) begin n_fail++;
      $display("FAIL reset_instr: got %h want %h", reg_instruction, 32'h0); end
    n_cmp++; if (reg_id_pc !== 32'h0) begin n_fail++;
      $display("FAIL reset_id_pc: got %h want %h", reg_id_pc, 32'h0); end
    n_cmp++; if (reg_pred_taken !== 1'b0 || reg_pred_target !== 32'h0) begin n_fail++;
      $display("FAIL reset_pred: got %b/%h want 0/0", reg_pred_taken, reg_pred_target); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 8; k++) begin
      adv();
      n_cmp++; if (reg_pc !== 32'(4 * (k + 1)) || reg_id_pc !== 32'(4 * k)) begin n_fail++;
        $display("FAIL seq_pc[%0d]: got %h/%h want %h/%h", k, reg_pc, reg_id_pc,
                 4 * (k + 1), 4 * k); end
      n_cmp++; if (reg_pred_taken !== 1'b0) begin n_fail++;
        $display("FAIL seq_taken[%0d]: got %b want 0", k, reg_pred_taken); end
    end
  endtask

  task automatic test_btb_train();
    imem[32'h40] = W_BEQ;
    step(0, 0, 0, 0, 1, 32'h40, 32'h100, 1);
    step(0, 0, 0, 0, 1, 32'h40, 32'h100, 1);
    flush_to(32'h40);
    adv();
    n_cmp++; if (reg_pc !== 32'h100 || reg_pred_target !== 32'h100) begin n_fail++;
      $display("FAIL btb_taken: got pc %h tgt %h want 100/100", reg_pc, reg_pred_target); end
    n_cmp++; if (reg_pred_taken !== 1'b1 || reg_id_pc !== 32'h40 || reg_instruction !== W_BEQ)
    begin n_fail++;
      $display("FAIL btb_taken_id: got %b %h %h want 1 40 %h", reg_pred_taken, reg_id_pc,
               reg_instruction, W_BEQ); end
    // 11 -> 10: still predicted taken.
    step(0, 0, 0, 0, 1, 32'h40, 32'h100, 0);
    flush_to(32'h40);
    adv();
    n_cmp++; if (reg_pc !== 32'h100) begin n_fail++;
      $display("FAIL btb_weak_taken: got %h want %h", reg_pc, 32'h100); end
    // 10 -> 01: now predicted not taken.
    step(0, 0, 0, 0, 1, 32'h40, 32'h100, 0);
    flush_to(32'h40);
    adv();
    n_cmp++; if (reg_pc !== 32'h44 || reg_pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL btb_not_taken: got %h/%b want 44/0", reg_pc, reg_pred_taken); end
  endtask

  task automatic test_call_return();
    imem[32'h200] = jal_word(32'h800);
    imem[32'h810] = W_JR31;
    imem[32'h204] = W_JR31;
    flush_to(32'h200);
    adv();
    n_cmp++; if (reg_pc !== 32'h800 || reg_pred_taken !== 1'b1) begin n_fail++;
      $display("FAIL jal_target: got %h/%b want 800/1", reg_pc, reg_pred_taken); end
    for (int k = 0; k < 4; k++) adv();
    adv();
    n_cmp++; if (reg_pc !== 32'h204 || reg_pred_target !== 32'h204) begin n_fail++;
      $display("FAIL jr31_return: got %h/%h want 204/204", reg_pc, reg_pred_target); end
    adv();
    n_cmp++; if (reg_pc !== 32'h208 || reg_pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL ras_empty_after_ret: got %h/%b want 208/0", reg_pc, reg_pred_taken); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_seq [10];
    exp_seq = '{32'h2000, 32'h3000, 32'h4000, 32'h5000, 32'h6000,
                32'h5004, 32'h4004, 32'h3004, 32'h2004, 32'h2008};
    for (int k = 1; k <= 5; k++) imem[32'(k * 32'h1000)] = jal_word(32'((k + 1) * 32'h1000));
    imem[32'h6000] = W_JR31;
    for (int k = 2; k <= 5; k++) imem[32'(k * 32'h1000 + 4)] = W_JR31;
    flush_to(32'h1000);
    for (int k = 0; k < 10; k++) begin
      adv();
      n_cmp++; if (reg_pc !== exp_seq[k]) begin n_fail++;
        $display("FAIL ras_nest[%0d]: got %h want %h", k, reg_pc, exp_seq[k]); end
    end
    n_cmp++; if (reg_pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL ras_underflow_taken: got %b want 0", reg_pred_taken); end
  endtask

  task automatic test_flush_stall_reset();
    step(1, 0, 1, 32'h300, 0, 0, 0, 0);
    n_cmp++; if (reg_pc !== 32'h300 || reg_instruction !== 32'h0 || reg_id_pc !== 32'h0 ||
                 reg_pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL flush_over_hazard: got %h %h %h %b want 300 0 0 0", reg_pc,
               reg_instruction, reg_id_pc, reg_pred_taken); end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (reg_pc !== 32'h300 || reg_id_pc !== 32'h0) begin n_fail++;
      $display("FAIL stall_hold: got %h/%h want 300/0", reg_pc, reg_id_pc); end
    // Leave a trained BTB entry and a RAS entry behind, then reset mid-stall.
    step(0, 0, 0, 0, 1, 32'h40, 32'h100, 1);
    step(0, 0, 0, 0, 1, 32'h40, 32'h100, 1);
    flush_to(32'h200);
    adv();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (reg_pc !== 32'h0 || reg_pred_target !== 32'h0 || reg_id_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %h %h %h want 0 0 0", reg_pc, reg_pred_target,
               reg_id_pc); end
    rst = 1'b0;
    model_reset();
    adv();
    n_cmp++; if (reg_pc !== 32'h4) begin n_fail++;
      $display("FAIL reset_release: got %h want %h", reg_pc, 32'h4); end
    flush_to(32'h40);
    adv();
    n_cmp++; if (reg_pc !== 32'h44) begin n_fail++;
      $display("FAIL reset_btb_clear: got %h want %h", reg_pc, 32'h44); end
    flush_to(32'h810);
    adv();
    n_cmp++; if (reg_pc !== 32'h814) begin n_fail++;
      $display("FAIL reset_ras_clear: got %h want %h", reg_pc, 32'h814); end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1:    w = 32'h0;
      2:       w = {6'h00, w[25:11], 5'd0, 6'h20};
      3:       w[31:26] = 6'h04;
      4:       w[31:26] = 6'h05;
      5:       w = {6'h02, 26'($urandom_range(0, 1023))};
      6:       w = {6'h03, 26'($urandom_range(0, 1023))};
      7, 8:    w = W_JR31;
      default: w = {6'h00, 5'($urandom_range(0, 30)), 15'd0, 6'h08};
    endcase
    return w;
  endfunction

  task automatic test_random();
    logic [31:0] fpc, upc, utg;
    bit fl, hz, cs, uv, utk;
    imem.delete();
    for (int a = 0; a < 1024; a++) imem[32'(a * 4)] = gen_instr();
    flush_to(32'h0);
    for (int k = 0; k < 3000; k++) begin
      fl  = ($urandom_range(0, 15) == 0);
      hz  = ($urandom_range(0, 7) == 0);
      cs  = ($urandom_range(0, 7) == 0);
      uv  = ($urandom_range(0, 2) == 0);
      utk = ($urandom_range(0, 1) == 1);
      fpc = 32'($urandom_range(0, 1023)) << 2;
      upc = ($urandom_range(0, 1) == 1) ? m_pc : 32'($urandom_range(0, 1023)) << 2;
      utg = 32'($urandom_range(0, 1023)) << 2;
      step(hz, cs, fl, fpc, uv, upc, utg, utk);
      n_cmp++; if (reg_pc !== m_pc) begin n_fail++;
        $display("FAIL rnd_pc[%0d]: got %h want %h", k, reg_pc, m_pc); end
      n_cmp++; if (reg_id_pc !== m_id_pc) begin n_fail++;
        $display("FAIL rnd_id_pc[%0d]: got %h want %h", k, reg_id_pc, m_id_pc); end
      n_cmp++; if (reg_instruction !== m_instr) begin n_fail++;
        $display("FAIL rnd_instr[%0d]: got %h want %h", k, reg_instruction, m_instr); end
      n_cmp++; if (reg_pred_taken !== m_ptk) begin n_fail++;
        $display("FAIL rnd_taken[%0d]: got %b want %b", k, reg_pred_taken, m_ptk); end
      n_cmp++; if (reg_pred_target !== m_ptgt) begin n_fail++;
        $display("FAIL rnd_target[%0d]: got %h want %h", k, reg_pred_target, m_ptgt); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_btb_train();
    test_call_return();
    test_ras_overflow();
    test_flush_stall_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_bpu.md
Name: fetch_bpu

Overview:
Parametrised instruction-fetch stage with a dynamic branch predictor. It replaces the fixed 1024-entry, externally written BHT with the following:
- a tagged branch target buffer (BTB) of 2-bit saturating counters, trained internally from the EX-stage resolve port;
- direct J/JAL target computation;
- a return-address stack (RAS) for JR $31.

It sits between the instruction memory and the IF/ID register. It honours the existing hazard, flush and cache-stall controls.

Parameters:
BTB_AW, 6, log2 of BTB entries (64).
TAG_W, 8, BTB tag width taken from pc[BTB_AW+2+TAG_W-1 : BTB_AW+2].
RAS_DEPTH, 4, RAS entries; must be a power of two and at least 2.
RESET_PC, 32'h0, fetch address after reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
instruction  in  32  imem data for reg_pc, combinational.
isHazard  in  1  load-use stall.
isCacheStall  in  1  memory stall.
isFlush  in  1  mispredict or redirect from EX.
flush_pc  in  32  correct next PC, valid with isFlush.
upd_valid  in  1  resolved BEQ/BNE in EX.
upd_pc  in  32  PC of the resolved branch.
upd_target  in  32  computed branch target.
upd_taken  in  1  actual branch outcome.
reg_pc  out  32  current fetch address, drives imem.
reg_id_pc  out  32  PC of reg_instruction.
reg_instruction  out  32  to decode.
reg_pred_taken  out  1  prediction made for reg_instruction.
reg_pred_target  out  32  predicted next PC, which EX compares against.

Behaviour:
- Reset: reg_pc=RESET_PC; reg_id_pc, reg_instruction (NOP), reg_pred_taken and reg_pred_target all 0. All BTB valid bits are cleared and the RAS count is 0. The BTB tag, target and counter arrays need no reset.
- Pre-decode of `instruction`:
  - BR: opcode BEQ/BNE.
  - J: opcode J.
  - JAL: opcode JAL.
  - JR31: opcode R, funct JR, rs=31.
  - Other JR: not predicted.
- Lookup is combinational. idx=reg_pc[BTB_AW+1:2]. hit = valid[idx] and tag match.
- Predicted next PC (npc) and taken flag:
  - BR with hit and ctr[1]=1 -> btb_target, taken=1.
  - J or JAL -> {pc4[31:28], instr[25:0], 2'b00}, taken=1.
  - JR31 with RAS count>0 -> RAS top, taken=1.
  - Otherwise -> pc4 = reg_pc+4, taken=0.
- Per-edge priority, where "advance" means no flush and no stall:
  - isFlush: reg_pc<=flush_pc; reg_instruction<=NOP; reg_pred_taken<=0; reg_id_pc<=0. There is no RAS push or pop.
  - Else if isHazard or isCacheStall: every register holds. No RAS push or pop.
  - Else (advance): reg_pc<=npc; reg_id_pc<=reg_pc; reg_instruction<=instruction; reg_pred_taken/target <= taken/npc.
- Latency: one cycle from fetch address to decode outputs. A redirect on flush costs exactly one bubble.
- RAS: circular buffer with pointer and count.
  - Push on advance with JAL: value reg_pc+4, since the pipeline has no delay slot.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH and the pointer wraps.
  - Pop on advance with a predicted JR31 decrements the count.
  - Pop when empty does nothing and gives no prediction.
  - Flush does not repair the RAS.
- BTB update, every clock edge with upd_valid, independent of stall and flush:
  - uidx and utag come from upd_pc.
  - Hit: the counter saturating-increments if taken, otherwise decrements (bounds 0..3). The target is rewritten when taken.
  - Miss and taken: allocate the entry with valid=1, tag, target and ctr=2'b10.
  - Miss and not taken: no change.
- Same-cycle update and lookup to the same index: the lookup sees the pre-update value.
- Asynchronous reset asserted mid-stall or mid-flush forces the reset values immediately. Release takes effect on the next edge.

Decomposition:
- The shared package (macros.v) holds the opcode/funct constants already used (OPCODE_I_BEQ, OPCODE_I_BNE, OPCODE_J_JUMP, OPCODE_JAL_JUMP, OPCODE_R, R_FUNC_JR) and NOP.
- Add one new constant there: BTB_CTR_INIT = 2'b10.
- One natural sub-module, `ras_stack`: push, pop, top and count, with the overwrite-on-full and ignore-pop-on-empty rules.
- The BTB array stays inline, as a flop array with a reset valid vector.

Test Plan:
1. Reset then release with 8 NOPs streamed -> reg_pc runs 0,4,8,…,0x20. reg_pred_taken=0 throughout.
2. BEQ at 0x40 resolved taken to 0x100 twice (upd_valid) -> on the next fetch of 0x40, reg_pc becomes 0x100 next cycle and reg_pred_target=0x100 (ctr=11).
3. Same BEQ then resolved not-taken twice -> ctr goes 11, 10, 01. The next fetch of 0x40 goes to 0x44 with reg_pred_taken=0.
4. JAL at 0x200 to 0x800, then JR $31 at 0x810 -> reg_pc goes 0x800, then 0x204 after the JR fetch. The RAS count returns to 0.
5. Five nested JALs with RAS_DEPTH=4, then five JR31 -> the first four return correctly (LIFO). The fifth gives no prediction (reg_pc=JR_pc+4).
6. isFlush with flush_pc=0x300 in the same cycle as isHazard -> reg_pc=0x300 and reg_instruction=NOP. Asserting rst mid-stall -> reg_pc=RESET_PC without waiting for a clock edge.
